// File: rtl/datapath_pkg.sv
// Shared datapath constants: bus widths and the fetch sequencer state encoding.
package datapath_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] FETCH   = 2'b01;
  localparam logic [1:0] HOLD    = 2'b10;
  localparam logic [1:0] ADVANCE = 2'b11;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads memory at pc, buffers the word for decode,
// and drives the pc register with the sequential or redirected next address.
module fetch_unit #(
  parameter int unsigned ADDR_W  = datapath_pkg::ADDR_W,
  parameter int unsigned INSTR_W = datapath_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               pc_load_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  import datapath_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic [ADDR_W-1:0]  next_pc_q, next_pc_d;
  logic               mem_req_q;

  // A same-cycle pulse counts as pending and beats an older latched target.
  logic               redir_any;
  logic [ADDR_W-1:0]  redir_addr;

  assign redir_any  = pend_q | branch_taken;
  assign redir_addr = branch_taken ? branch_target : tgt_q;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    next_pc_d = next_pc_q;
    if (branch_taken && state_q != HOLD) begin
      pend_d = 1'b1;
      tgt_d  = branch_target;
    end
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          if (redir_any) begin
            next_pc_d = redir_addr;
            pend_d    = 1'b0;
            state_d   = ADVANCE;
          end else begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          valid_d   = 1'b0;
          next_pc_d = branch_target;
          state_d   = ADVANCE;
        end else if (instr_ready) begin
          valid_d   = 1'b0;
          next_pc_d = pc_addr + ADDR_W'(1);
          state_d   = ADVANCE;
        end
      end
      ADVANCE: begin
        if (redir_any) begin
          next_pc_d = redir_addr;
          pend_d    = 1'b0;
        end
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      tgt_q     <= '0;
      next_pc_q <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
      next_pc_q <= next_pc_d;
      mem_req_q <= (state_d == FETCH);
    end
  end

  assign pc_load_n   = (state_q != ADVANCE);
  assign pc_in       = (state_q == ADVANCE && redir_any) ? redir_addr : next_pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_req_q ? pc_addr : '0;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a pc register model, a wait-state
// memory responder and a transaction-level expected-address model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [15:0] pc_addr;
  logic [15:0] pc_in;
  logic        pc_load_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;

  int          vectors = 0;
  int          errors = 0;
  logic [15:0] pc_init = '0;
  int          mem_wait = 0;
  int          wcnt = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .pc_addr      (pc_addr),
    .pc_in        (pc_in),
    .pc_load_n    (pc_load_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  // External pc register.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_addr <= pc_init;
    else if (!pc_load_n) pc_addr <= pc_in;
  end

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a * 16'h1111 + 16'h1234;
  endfunction

  // Memory acks after mem_wait idle request cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = memf(mem_addr);
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] p);
    run           = 1'b0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    pc_init       = p;
    rst           = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(16'h0000);
    vectors += 6;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req got %b want 0", mem_req); end
    if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
    if (pc_in !== 16'h0) begin errors++; $display("FAIL reset pc_in got %h want 0", pc_in); end
    if (pc_load_n !== 1'b1) begin errors++; $display("FAIL reset pc_load_n got %b want 1", pc_load_n); end
    if (instr !== 16'h0) begin errors++; $display("FAIL reset instr got %h want 0", instr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid got %b want 0", instr_valid); end
  endtask

  task automatic test_basic();
    do_reset(16'h0000);
    mem_wait = 0;
    run = 1'b1;
    step();
    vectors += 2;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", mem_req); end
    if (mem_addr !== 16'h0) begin errors++; $display("FAIL basic_addr got %h want 0", mem_addr); end
    step();
    vectors += 2;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", instr_valid); end
    if (instr !== 16'h1234) begin errors++; $display("FAIL basic_instr got %h want 1234", instr); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vectors += 3;
    if (pc_load_n !== 1'b0) begin errors++; $display("FAIL basic_load got %b want 0", pc_load_n); end
    if (pc_in !== 16'h0001) begin errors++; $display("FAIL basic_pc_in got %h want 0001", pc_in); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", instr_valid); end
    step();
    vectors += 2;
    if (pc_load_n !== 1'b1) begin errors++; $display("FAIL basic_load_pulse got %b want 1", pc_load_n); end
    if (mem_addr !== 16'h0001) begin errors++; $display("FAIL basic_next_addr got %h want 0001", mem_addr); end
  endtask

  task automatic test_wait();
    int cnt;
    int bad;
    do_reset(16'h0010);
    mem_wait = 3;
    run = 1'b1;
    step();
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      if (mem_req) begin
        cnt++;
        if (mem_addr !== 16'h0010) bad++;
      end
      step();
    end
    vectors += 3;
    if (cnt != 4) begin errors++; $display("FAIL wait_req_cycles got %0d want 4", cnt); end
    if (bad != 0) begin errors++; $display("FAIL wait_addr_stable got %0d unstable want 0", bad); end
    if (instr !== memf(16'h0010)) begin errors++; $display("FAIL wait_instr got %h want %h", instr, memf(16'h0010)); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vectors++;
    if (pc_load_n !== 1'b0 || pc_in !== 16'h0011) begin
      errors++; $display("FAIL wait_advance got load_n=%b pc_in=%h want 0/0011", pc_load_n, pc_in);
    end
    mem_wait = 0;
  endtask

  task automatic test_wrap();
    int i;
    do_reset(16'hFFFF);
    mem_wait = 0;
    run = 1'b1;
    instr_ready = 1'b1;
    for (i = 0; i < 10 && pc_load_n; i++) step();
    instr_ready = 1'b0;
    vectors++;
    if (pc_load_n !== 1'b0 || pc_in !== 16'h0000) begin
      errors++; $display("FAIL wrap got load_n=%b pc_in=%h want 0/0000", pc_load_n, pc_in);
    end
  endtask

  task automatic test_branch_hold();
    do_reset(16'h0020);
    mem_wait = 0;
    run = 1'b1;
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    instr_ready   = 1'b1;
    step();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    vectors += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL bhold_valid got %b want 0", instr_valid); end
    if (pc_load_n !== 1'b0 || pc_in !== 16'h0040) begin
      errors++; $display("FAIL bhold_pc got load_n=%b pc_in=%h want 0/0040", pc_load_n, pc_in);
    end
    step();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++; $display("FAIL bhold_fetch got req=%b addr=%h want 1/0040", mem_req, mem_addr);
    end
  endtask

  task automatic test_branch_fetch();
    int seen;
    do_reset(16'h0030);
    mem_wait = 3;
    run = 1'b1;
    step();
    branch_taken  = 1'b1;
    branch_target = 16'h0080;
    step();
    branch_taken = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && pc_load_n; i++) begin
      if (instr_valid) seen++;
      step();
    end
    vectors += 2;
    if (seen != 0) begin errors++; $display("FAIL bfetch_discard got %0d valid cycles want 0", seen); end
    if (pc_load_n !== 1'b0 || pc_in !== 16'h0080) begin
      errors++; $display("FAIL bfetch_pc got load_n=%b pc_in=%h want 0/0080", pc_load_n, pc_in);
    end
    mem_wait = 0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset(16'h0005);
    mem_wait = 5;
    run = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors += 3;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rfetch_req got %b want 0", mem_req); end
    if (mem_addr !== 16'h0) begin errors++; $display("FAIL rfetch_addr got %h want 0", mem_addr); end
    if (pc_load_n !== 1'b1 || pc_in !== 16'h0) begin
      errors++; $display("FAIL rfetch_pc got load_n=%b pc_in=%h want 1/0000", pc_load_n, pc_in);
    end
    run = 1'b0;
    step();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!pc_load_n || mem_req) pulses++;
    end
    vectors++;
    if (pulses != 0) begin errors++; $display("FAIL rfetch_quiet got %0d active cycles want 0", pulses); end
    mem_wait = 0;
    run = 1'b1;
    step();
    step();
    vectors++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL rhold_pre got %b want 1", instr_valid); end
    rst = 1'b0;
    #1;
    vectors += 2;
    if (instr_valid !== 1'b0 || instr !== 16'h0) begin
      errors++; $display("FAIL rhold_buf got valid=%b instr=%h want 0/0000", instr_valid, instr);
    end
    if (pc_load_n !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rhold_ctl got load_n=%b req=%b want 1/0", pc_load_n, mem_req);
    end
    run = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] exp_addr, exp_next, bt;
    int w, s, lat;
    bit br;
    do_reset(16'($urandom));
    exp_addr = pc_init;
    w = $urandom_range(0, 3);
    mem_wait = w;
    run = 1'b1;
    step();
    for (int n = 0; n < 40; n++) begin
      lat = 0;
      while (!instr_valid && lat < 20) begin
        step();
        lat++;
      end
      vectors += 2;
      if (lat != w + 1) begin errors++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, lat, w + 1); end
      if (instr !== memf(exp_addr)) begin
        errors++; $display("FAIL rnd_instr n=%0d got %h want %h", n, instr, memf(exp_addr));
      end
      s = $urandom_range(0, 2);
      for (int k = 0; k < s; k++) step();
      vectors++;
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL rnd_stall n=%0d got %b want 1", n, instr_valid); end
      br = ($urandom_range(0, 3) == 0);
      bt = 16'($urandom);
      branch_taken  = br;
      branch_target = bt;
      instr_ready   = br ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      branch_taken = 1'b0;
      instr_ready  = 1'b0;
      exp_next = br ? bt : exp_addr + 16'd1;
      vectors += 2;
      if (pc_load_n !== 1'b0 || pc_in !== exp_next) begin
        errors++; $display("FAIL rnd_advance n=%0d got load_n=%b pc_in=%h want 0/%h", n, pc_load_n, pc_in, exp_next);
      end
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop n=%0d got %b want 0", n, instr_valid); end
      w = $urandom_range(0, 3);
      mem_wait = w;
      step();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== exp_next) begin
        errors++; $display("FAIL rnd_fetch n=%0d got req=%b addr=%h want 1/%h", n, mem_req, mem_addr, exp_next);
      end
      exp_addr = exp_next;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_wrap();
    test_branch_hold();
    test_branch_fetch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
